// File: rtl/mvb_rx_frame_buffer.sv
// Single-frame receive buffer behind the MVB decoder: captures one frame of up to
// 32 words with its error status, holds it for readout and drops frames arriving meanwhile.
module mvb_rx_frame_buffer (
  input  logic        clk_24M,
  input  logic        rst,
  input  logic        word_valid,
  input  logic [15:0] word_data,
  input  logic        frame_over,
  input  logic [6:0]  frame_length,
  input  logic        err_length,
  input  logic        err_signal,
  input  logic        err_delimiter,
  input  logic        err_quality,
  input  logic        err_crc,
  input  logic        rd_en,
  output logic        frame_ready,
  output logic [5:0]  frame_words,
  output logic [7:0]  frame_status,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_last,
  output logic [7:0]  drop_cnt,
  output logic [15:0] led_word
);

  typedef enum logic [1:0] {IDLE, RECV, HOLD, SKIP} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_mem [0:31];
  logic [5:0]  r_wptr, r_rptr;
  logic [4:0]  r_err;
  logic        r_ovf, r_in_frame;
  logic [15:0] r_word0;
  logic [5:0]  r_frame_words;
  logic [7:0]  r_frame_status;
  logic        r_rd_valid, r_rd_last;
  logic [15:0] r_rd_data;
  logic [7:0]  r_drop_cnt;
  logic [15:0] r_led_word;

  logic        w_idle, w_recv, w_hold, w_skip;
  logic [4:0]  w_err_in, w_err_nxt;
  logic        w_store, w_ovf_nxt, w_hold_enter, w_rd, w_rd_done;
  logic        w_in_frame_nxt, w_drop_inc, w_len_err;
  logic [4:0]  w_waddr;
  logic [5:0]  w_wptr_nxt;
  logic [6:0]  w_status_lo;

  assign w_idle   = (r_state == IDLE);
  assign w_recv   = (r_state == RECV);
  assign w_hold   = (r_state == HOLD);
  assign w_skip   = (r_state == SKIP);
  assign w_err_in = {err_crc, err_quality, err_delimiter, err_signal, err_length};

  // A full store (wptr=32) turns further words into the overflow flag.
  assign w_store      = word_valid & (w_idle | (w_recv & ~r_wptr[5]));
  assign w_waddr      = w_idle ? 5'd0 : r_wptr[4:0];
  assign w_wptr_nxt   = (w_recv & w_store) ? r_wptr + 6'd1 : r_wptr;
  assign w_err_nxt    = r_err | w_err_in;
  assign w_ovf_nxt    = r_ovf | (w_recv & word_valid & r_wptr[5]);
  assign w_hold_enter = w_recv & frame_over;

  // Status is built from the post-update values so the frame_over cycle counts.
  assign w_len_err   = ({1'b0, w_wptr_nxt} != frame_length);
  assign w_status_lo = {w_ovf_nxt, w_err_nxt, w_len_err};

  assign w_rd      = w_hold & rd_en;
  assign w_rd_done = w_rd & (r_rptr == r_frame_words - 6'd1);

  assign w_in_frame_nxt = frame_over ? 1'b0 : (word_valid | r_in_frame);
  assign w_drop_inc     = (w_hold | w_skip) & frame_over;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (word_valid) w_state_nxt = RECV;
      RECV:    if (frame_over) w_state_nxt = HOLD;
      HOLD:    if (w_rd_done)  w_state_nxt = w_in_frame_nxt ? SKIP : IDLE;
      SKIP:    if (frame_over) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_24M) begin
    if (w_store) r_mem[w_waddr] <= word_data;
  end

  always_ff @(posedge clk_24M) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_err          <= '0;
      r_ovf          <= 1'b0;
      r_in_frame     <= 1'b0;
      r_word0        <= '0;
      r_frame_words  <= '0;
      r_frame_status <= '0;
      r_rd_valid     <= 1'b0;
      r_rd_last      <= 1'b0;
      r_rd_data      <= '0;
      r_drop_cnt     <= '0;
      r_led_word     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= w_rd;
      r_rd_last  <= w_rd_done;
      r_in_frame <= (w_hold & ~w_rd_done) ? w_in_frame_nxt : 1'b0;
      if (w_idle & word_valid) begin
        r_wptr  <= 6'd1;
        r_err   <= '0;
        r_ovf   <= 1'b0;
        r_word0 <= word_data;
      end else if (w_recv) begin
        r_wptr <= w_wptr_nxt;
        r_err  <= w_err_nxt;
        r_ovf  <= w_ovf_nxt;
      end
      if (w_hold_enter) begin
        r_frame_words  <= w_wptr_nxt;
        r_frame_status <= {~|w_status_lo, w_status_lo};
        if (~|w_status_lo) r_led_word <= r_word0;
      end
      if (w_rd) begin
        r_rd_data <= r_mem[r_rptr[4:0]];
        r_rptr    <= w_rd_done ? 6'd0 : r_rptr + 6'd1;
      end
      if (w_drop_inc && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign frame_ready  = w_hold;
  assign frame_words  = r_frame_words;
  assign frame_status = r_frame_status;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign rd_last      = r_rd_last;
  assign drop_cnt     = r_drop_cnt;
  assign led_word     = r_led_word;

endmodule
